// File: rtl/shift_pkg.sv
// Shared constants for the pipelined shifter: data/count widths and op encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_pkg;

  // Data width is the ISA word size; count width is log2(WIDTH) and sets the stage count.
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

endpackage

// File: rtl/shift_stage.sv
// One shifter stage: conditional rol/sll/ror/srl by AMT, plus its valid/data/count/op register.
// Latency: 1 cycle (registered output).
// Backpressure: loads only when i_ld is high, otherwise holds all contents.
// Ports: clk/rst_n (sync active-low), i_ld load enable, i_vld/i_data/i_cnt/i_op incoming item,
//        i_en shift enable (this stage's count bit), o_vld/o_data/o_cnt/o_op registered item.
module shift_stage
  import shift_pkg::*;
#(
  parameter int AMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld,
  input  logic             i_vld,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [1:0]       i_op,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt,
  output logic [1:0]       o_op
);

  logic [WIDTH-1:0] w_shf;

  logic             r_vld;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;

  always_comb begin
    w_shf = i_data;
    if (i_en) begin
      case (i_op)
        OP_SLL:  w_shf = i_data << AMT;
        OP_SRL:  w_shf = i_data >> AMT;
        OP_ROL:  w_shf = (i_data << AMT) | (i_data >> (WIDTH - AMT));
        default: w_shf = (i_data >> AMT) | (i_data << (WIDTH - AMT));
      endcase
    end
  end

  // Count and op travel with the item so mixed operations never interfere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
    end else if (i_ld) begin
      r_vld  <= i_vld;
      r_data <= w_shf;
      r_cnt  <= i_cnt;
      r_op   <= i_op;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_cnt  = r_cnt;
  assign o_op   = r_op;

endmodule

// File: rtl/shift_pipe.sv
// Four-stage pipelined 16-bit shifter/rotator; stage k shifts by 2^k when count bit k is set.
// Latency: item accepted at edge N is presented on out_valid/out_data at edge N+3.
// Backpressure: valid/ready chain; empty stages accept while downstream stalls, full pipe deasserts in_ready.
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/in_data/in_cnt/in_op operation input
//        (op 00 rol, 01 sll, 10 ror, 11 srl); out_valid/out_ready/out_data result output.
module shift_pipe
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Element 0 of the data/count/op arrays is the pipe input; element i+1 is stage i's register.
  logic [CNT_W-1:0] w_sv;
  logic [CNT_W-1:0] w_rdy;
  logic             w_acc;
  logic [WIDTH-1:0] w_data [0:CNT_W];
  logic [CNT_W-1:0] w_cnt  [0:CNT_W];
  logic [1:0]       w_op   [0:CNT_W];
  logic             w_unused;

  assign w_data[0] = in_data;
  assign w_cnt[0]  = in_cnt;
  assign w_op[0]   = in_op;

  assign in_ready  = w_rdy[0] & rst_n;
  assign w_acc     = in_valid & in_ready;

  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_stage
    logic w_vin;

    // rdy[i] = ~v[i] | rdy[i+1], unrolled: a stage can load unless it and every
    // stage after it are occupied while the consumer is stalled.
    assign w_rdy[gi] = out_ready | ~(&w_sv[CNT_W-1:gi]);

    if (gi == 0) begin : g_first
      assign w_vin = w_acc;
    end else begin : g_next
      assign w_vin = w_sv[gi-1];
    end

    shift_stage #(
      .AMT (1 << gi)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_ld   (w_rdy[gi]),
      .i_vld  (w_vin),
      .i_en   (w_cnt[gi][gi]),
      .i_data (w_data[gi]),
      .i_cnt  (w_cnt[gi]),
      .i_op   (w_op[gi]),
      .o_vld  (w_sv[gi]),
      .o_data (w_data[gi+1]),
      .o_cnt  (w_cnt[gi+1]),
      .o_op   (w_op[gi+1])
    );
  end

  assign out_valid = w_sv[CNT_W-1];
  assign out_data  = w_data[CNT_W];

  // Count/op of the last stage have no consumer; they exist only to keep stages identical.
  assign w_unused = ^{w_cnt[CNT_W], w_op[CNT_W]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: queue-based reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: bench drives random out_ready stalls.
module tb_shift_pipe;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_cnt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  shift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          edges = 0;
  int          dut_retired = 0;
  logic [15:0] q_exp[$];
  int          q_t[$];
  bit          just_reset = 1'b0;

  // Whole-word reference: a single shift by the full count on a widened operand.
  function automatic logic [15:0] ref_result(input logic [15:0] d, input int c, input logic [1:0] op);
    logic [31:0] x;
    logic [31:0] r;
    x = {16'h0000, d};
    case (op)
      2'b01:   r = x << c;
      2'b11:   r = x >> c;
      2'b00:   r = (x << c) | (x >> (16 - c));
      default: r = (x >> c) | (x << (16 - c));
    endcase
    return r[15:0];
  endfunction

  // Oldest item is visible once three edges have passed since its acceptance edge.
  function automatic bit m_valid();
    return (q_exp.size() > 0) && (q_t[0] + 3 <= edges);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model update at each rising edge, from pre-edge input values.
  always @(posedge clk) begin
    bit mv;
    bit mrdy;
    mv   = m_valid();
    mrdy = rst_n && (out_ready || q_exp.size() < 4);
    edges++;
    if (!rst_n) begin
      q_exp.delete();
      q_t.delete();
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (mv && out_ready) begin
        void'(q_exp.pop_front());
        void'(q_t.pop_front());
      end
      if (in_valid && mrdy) begin
        q_exp.push_back(ref_result(in_data, int'(in_cnt), in_op));
        q_t.push_back(edges);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (edges > 0) begin
      chk("in_ready", 32'(in_ready), 32'(rst_n && (out_ready || q_exp.size() < 4)));
      chk("out_valid", 32'(out_valid), 32'(m_valid()));
      if (m_valid()) chk("out_data", 32'(out_data), 32'(q_exp[0]));
      if (just_reset) chk("out_data_after_reset", 32'(out_data), 32'h0);
      if (out_valid && out_ready) dut_retired++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    in_op    = op;
    ok       = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic run_one(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                         input logic [15:0] exp, input string name);
    bit ok;
    int k;
    out_ready = 1'b1;
    send(d, c, op, ok);
    if (ok) begin
      k = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) break;
        k++;
      end
      chk({name, "_latency"}, 32'(k), 32'd3);
      chk({name, "_data"}, 32'(out_data), 32'(exp));
      step();
    end
  endtask

  initial begin
    int  idx;
    bit  rdy;
    bit  ok;
    int  base;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'h1);
    step();

    // Directed single operations
    run_one(16'h0001, 4'd15, OP_SLL, 16'h8000, "sll15");
    run_one(16'h8000, 4'd4,  OP_SRL, 16'h0800, "srl4");
    run_one(16'h0001, 4'd1,  OP_ROR, 16'h8000, "ror1");
    run_one(16'h8001, 4'd4,  OP_ROL, 16'h0018, "rol4");
    run_one(16'hFFFF, 4'd15, OP_SRL, 16'h0001, "srl15");
    run_one(16'h0001, 4'd15, OP_ROL, 16'h8000, "rol15");
    run_one(16'h8000, 4'd15, OP_ROR, 16'h0001, "ror15");
    for (int op = 0; op < 4; op++) run_one(16'hA5A5, 4'd0, 2'(op), 16'hA5A5, "cnt0");

    // Back-pressure: six back-to-back ops into a stalled consumer
    base = dut_retired;
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000 + 16'(idx);
      in_cnt   = 4'd0;
      in_op    = OP_SLL;
      @(negedge clk);
      rdy = in_ready;
      step();
      if (rdy) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    @(negedge clk);
    chk("bp_full_in_ready", 32'(in_ready), 32'h0);
    step();

    // Full pipe, consumer ready and new item offered in the same cycle
    out_ready = 1'b1;
    @(negedge clk);
    chk("simul_in_ready", 32'(in_ready), 32'h1);
    chk("simul_out_data", 32'(out_data), 32'h1000);
    step();
    idx++;
    out_ready = 1'b0;
    in_data = 16'h1000 + 16'(idx);
    @(negedge clk);
    chk("occupancy_4_in_ready", 32'(in_ready), 32'h0);
    chk("occupancy_4_out_data", 32'(out_data), 32'h1001);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("bp_all_retired", 32'(dut_retired - base), 32'd6);

    // Reset with three items in flight
    out_ready = 1'b0;
    send(16'h1234, 4'd3, OP_ROL, ok);
    send(16'h5678, 4'd7, OP_SRL, ok);
    send(16'h9ABC, 4'd9, OP_SLL, ok);
    step();
    @(negedge clk);
    chk("prefault_out_valid", 32'(out_valid), 32'h1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_data", 32'(out_data), 32'h0);
    step();
    base = dut_retired;
    run_one(16'h8001, 4'd4, OP_ROL, 16'h0018, "after_rst");
    repeat (6) step();
    chk("after_rst_single", 32'(dut_retired - base), 32'd1);

    // Randomized traffic with stalls and occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      in_cnt    = 4'($urandom_range(0, 15));
      in_op     = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 399) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
